// File: rtl/pp_buf_pkg.sv
// Shared types and width helpers for the ping-pong bank buffer.
package pp_buf_pkg;

  typedef enum logic [1:0] {
    StEmpty    = 2'd0,
    StFilling  = 2'd1,
    StFull     = 2'd2,
    StDraining = 2'd3
  } bank_state_e;

  function automatic int unsigned bank_w(int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned len_w(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned cnt_w(int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pp_bank_mem.sv
// One buffer bank: register array with a synchronous write port and an asynchronous read port.
module pp_bank_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pp_bank_ctrl.sv
// N-bank ping-pong buffer: the writer fills banks in rotation, the reader drains completed
// banks in the same order.
module pp_bank_ctrl
  import pp_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned NUM_BANKS  = 2,
  localparam int unsigned AW        = $clog2(DEPTH),
  localparam int unsigned BW        = bank_w(NUM_BANKS),
  localparam int unsigned LW        = len_w(DEPTH),
  localparam int unsigned CW        = cnt_w(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_flush,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic [LW-1:0]         rd_len,
  output logic [BW-1:0]         wr_bank,
  output logic [BW-1:0]         rd_bank,
  output logic [CW-1:0]         full_cnt
);

  bank_state_e           state_q [NUM_BANKS];
  logic [LW-1:0]         len_q   [NUM_BANKS];
  logic [BW-1:0]         wr_bank_q, rd_bank_q;
  logic [AW-1:0]         wr_addr_q, rd_addr_q;
  logic [CW-1:0]         full_cnt_q;
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

  logic          wr_acc, wr_close, rd_acc, rd_done;
  logic [LW-1:0] wr_len_new, rd_len_cur;
  bank_state_e   wr_state, rd_state;

  always_comb begin
    wr_state = state_q[wr_bank_q];
    rd_state = state_q[rd_bank_q];
    wr_ready = (wr_state == StEmpty) || (wr_state == StFilling);
    rd_valid = (rd_state == StFull) || (rd_state == StDraining);

    wr_acc     = wr_valid && wr_ready;
    wr_len_new = wr_acc ? LW'(wr_addr_q) + LW'(1) : LW'(wr_addr_q);
    // A flush closes the bank only if it holds data, including a word written this cycle.
    wr_close   = (wr_acc && (wr_addr_q == AW'(DEPTH - 1)))
              || (wr_flush && (wr_acc || (wr_state == StFilling)));

    rd_len_cur = len_q[rd_bank_q];
    rd_last    = rd_valid && (LW'(rd_addr_q) == rd_len_cur - LW'(1));
    rd_acc     = rd_valid && rd_ready;
    rd_done    = rd_acc && rd_last;

    rd_data    = rd_valid ? bank_rdata[rd_bank_q] : '0;
    rd_len     = rd_valid ? rd_len_cur : '0;
    wr_bank    = wr_bank_q;
    rd_bank    = rd_bank_q;
    full_cnt   = full_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        state_q[i] <= StEmpty;
        len_q[i]   <= '0;
      end
      wr_bank_q  <= '0;
      rd_bank_q  <= '0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      full_cnt_q <= '0;
    end else begin
      if (wr_acc && (wr_state == StEmpty)) state_q[wr_bank_q] <= StFilling;
      if (wr_close) begin
        state_q[wr_bank_q] <= StFull;
        len_q[wr_bank_q]   <= wr_len_new;
        wr_addr_q          <= '0;
        wr_bank_q          <= (wr_bank_q == BW'(NUM_BANKS - 1)) ? '0 : wr_bank_q + BW'(1);
      end else if (wr_acc) begin
        wr_addr_q <= wr_addr_q + AW'(1);
      end

      // Read and write banks never coincide, so these updates touch a different bank.
      if (rd_acc) begin
        if (rd_last) begin
          state_q[rd_bank_q] <= StEmpty;
          rd_addr_q          <= '0;
          rd_bank_q          <= (rd_bank_q == BW'(NUM_BANKS - 1)) ? '0 : rd_bank_q + BW'(1);
        end else begin
          state_q[rd_bank_q] <= StDraining;
          rd_addr_q          <= rd_addr_q + AW'(1);
        end
      end

      full_cnt_q <= full_cnt_q + CW'(wr_close) - CW'(rd_done);
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    pp_bank_mem #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
    ) u_mem (
      .clk  (clk),
      .we   (wr_acc && (wr_bank_q == BW'(b))),
      .waddr(wr_addr_q),
      .wdata(wr_data),
      .raddr(rd_addr_q),
      .rdata(bank_rdata[b])
    );
  end

endmodule

// File: tb/tb_pp_bank_ctrl.sv
// Randomised and directed bench for pp_bank_ctrl against a queue-based bank model.
module tb_pp_bank_ctrl;

  localparam int NB  = 2;
  localparam int DEP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0, wr_flush = 1'b0, rd_ready = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, rd_valid, rd_last;
  logic [7:0] rd_data;
  logic [2:0] rd_len;
  logic [0:0] wr_bank, rd_bank;
  logic [1:0] full_cnt;

  // Second instance: 3 banks of 5 words, used for the mid-drain reset scenario.
  logic       rst3_n = 1'b0;
  logic       b_wv = 1'b0, b_wf = 1'b0, b_rr = 1'b0;
  logic [7:0] b_wd = 8'h00;
  logic       b_wr_ready, b_rd_valid, b_rd_last;
  logic [7:0] b_rd_data;
  logic [2:0] b_rd_len;
  logic [1:0] b_wr_bank, b_rd_bank, b_full_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pp_bank_ctrl #(.DATA_WIDTH(8), .DEPTH(DEP), .NUM_BANKS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .wr_flush(wr_flush), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .rd_len(rd_len), .wr_bank(wr_bank), .rd_bank(rd_bank),
    .full_cnt(full_cnt)
  );

  pp_bank_ctrl #(.DATA_WIDTH(8), .DEPTH(5), .NUM_BANKS(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .wr_valid(b_wv), .wr_ready(b_wr_ready), .wr_data(b_wd),
    .wr_flush(b_wf), .rd_valid(b_rd_valid), .rd_ready(b_rr), .rd_data(b_rd_data),
    .rd_last(b_rd_last), .rd_len(b_rd_len), .wr_bank(b_wr_bank), .rd_bank(b_rd_bank),
    .full_cnt(b_full_cnt)
  );

  logic [17:0] obs;
  logic [19:0] obs3;
  assign obs  = {wr_ready, rd_valid, rd_data, rd_last, rd_len, wr_bank, rd_bank, full_cnt};
  assign obs3 = {b_wr_ready, b_rd_valid, b_rd_data, b_rd_last, b_rd_len, b_wr_bank, b_rd_bank,
                 b_full_cnt};

  // Model: closed banks as a queue of lengths plus their words in order; the open bank's words.
  int         m_lens [$];
  logic [7:0] m_words [$];
  logic [7:0] m_fill [$];
  int         m_pos, m_wr_bank, m_rd_bank;
  logic       m_wacc;

  function automatic logic [17:0] m_exp();
    logic       v    = m_lens.size() > 0;
    logic [7:0] d    = v ? m_words[0] : 8'h00;
    int         len  = v ? m_lens[0] : 0;
    logic       last = v && (m_pos == len - 1);
    logic       wrt  = m_lens.size() < NB;
    int         cnt  = m_lens.size();
    logic [2:0] len3 = len[2:0];
    logic [1:0] cnt2 = cnt[1:0];
    logic       wb   = m_wr_bank[0];
    logic       rb   = m_rd_bank[0];
    return {wrt, v, d, last, len3, wb, rb, cnt2};
  endfunction

  task automatic model_reset();
    m_lens.delete();
    m_words.delete();
    m_fill.delete();
    m_pos = 0; m_wr_bank = 0; m_rd_bank = 0; m_wacc = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic step(input logic wv, input logic [7:0] wd, input logic wf, input logic rr);
    logic wrt, wa, ra;
    wrt = m_lens.size() < NB;
    wa  = wv && wrt;
    ra  = rr && (m_lens.size() > 0);
    wr_valid = wv; wr_data = wd; wr_flush = wf; rd_ready = rr;
    @(posedge clk); #1;
    wr_valid = 1'b0; wr_flush = 1'b0; rd_ready = 1'b0;
    if (ra) begin
      void'(m_words.pop_front());
      m_pos++;
      if (m_pos == m_lens[0]) begin
        void'(m_lens.pop_front());
        m_pos = 0;
        m_rd_bank = (m_rd_bank + 1) % NB;
      end
    end
    if (wa) m_fill.push_back(wd);
    if ((wa && m_fill.size() == DEP) || (wf && wrt && m_fill.size() > 0)) begin
      foreach (m_fill[i]) m_words.push_back(m_fill[i]);
      m_lens.push_back(m_fill.size());
      m_fill.delete();
      m_wr_bank = (m_wr_bank + 1) % NB;
    end
    m_wacc = wa;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 18'b1_0_00000000_0_000_0_0_00)
      $display("FAIL reset_hold: got %h want %h", obs, 18'b1_0_00000000_0_000_0_0_00);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    n_checks++;
    if (obs !== m_exp()) $display("FAIL reset_release: got %h want %h", obs, m_exp());
    else n_pass++;
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
      n_checks++;
      if (obs !== m_exp()) $display("FAIL fill_write%0d: got %h want %h", i, obs, m_exp());
      else n_pass++;
    end
    n_checks++;
    if ({rd_valid, rd_data, rd_len, wr_bank, full_cnt} !== {1'b1, 8'h10, 3'd4, 1'b1, 2'd1})
      $display("FAIL fill_done: got %h want %h", {rd_valid, rd_data, rd_len, wr_bank, full_cnt},
               {1'b1, 8'h10, 3'd4, 1'b1, 2'd1});
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({rd_data, rd_last} !== {8'h10 + 8'(i), i == 3})
        $display("FAIL drain_word%0d: got %h/%b want %h/%b", i, rd_data, rd_last,
                 8'h10 + 8'(i), i == 3);
      else n_pass++;
      step(1'b0, 8'h00, 1'b0, 1'b1);
      n_checks++;
      if (obs !== m_exp()) $display("FAIL drain_step%0d: got %h want %h", i, obs, m_exp());
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int   guard;
    logic seen_last;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
      n_checks++;
      if (obs !== m_exp()) $display("FAIL bp_write%0d: got %h want %h", i, obs, m_exp());
      else n_pass++;
    end
    n_checks++;
    if ({wr_ready, full_cnt} !== {1'b0, 2'd2})
      $display("FAIL bp_full: got %b/%0d want 0/2", wr_ready, full_cnt);
    else n_pass++;
    // Held word plus a flush while full: neither may change anything.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 8'h28, 1'b1, 1'b0);
      n_checks++;
      if (obs !== m_exp()) $display("FAIL bp_hold%0d: got %h want %h", i, obs, m_exp());
      else n_pass++;
    end
    guard = 0;
    seen_last = 1'b0;
    m_wacc = 1'b0;
    while (!m_wacc && guard < 12) begin
      n_checks++;
      if (seen_last && wr_ready !== 1'b1)
        $display("FAIL bp_ready_after_last: got %b want 1", wr_ready);
      else n_pass++;
      seen_last = rd_last;
      step(1'b1, 8'h28, 1'b0, 1'b1);
      n_checks++;
      if (obs !== m_exp()) $display("FAIL bp_drain%0d: got %h want %h", guard, obs, m_exp());
      else n_pass++;
      guard++;
    end
    n_checks++;
    if (!m_wacc) $display("FAIL bp_accept_timeout: got 0 accepts want 1");
    else n_pass++;
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if ({rd_valid, rd_data, rd_len, rd_bank} !== {1'b1, 8'h28, 3'd1, 1'b0})
      $display("FAIL bp_word28: got %h want %h", {rd_valid, rd_data, rd_len, rd_bank},
               {1'b1, 8'h28, 3'd1, 1'b0});
    else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    step(1'b1, 8'hA0, 1'b0, 1'b0);
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if ({rd_len, rd_data, rd_last} !== {3'd2, 8'hA0, 1'b0})
      $display("FAIL flush_len: got %h want %h", {rd_len, rd_data, rd_last}, {3'd2, 8'hA0, 1'b0});
    else n_pass++;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if ({rd_data, rd_last} !== {8'hA1, 1'b1})
      $display("FAIL flush_last: got %h/%b want a1/1", rd_data, rd_last);
    else n_pass++;
    step(1'b1, 8'hA2, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if ({rd_valid, rd_data, rd_len, rd_bank} !== {1'b1, 8'hA2, 3'd1, 1'b1})
      $display("FAIL flush_next: got %h want %h", {rd_valid, rd_data, rd_len, rd_bank},
               {1'b1, 8'hA2, 3'd1, 1'b1});
    else n_pass++;
    n_checks++;
    if (obs !== m_exp()) $display("FAIL flush_model: got %h want %h", obs, m_exp());
    else n_pass++;
  endtask

  task automatic test_flush_edges();
    do_reset();
    step(1'b1, 8'hB0, 1'b0, 1'b0);
    step(1'b1, 8'hB1, 1'b0, 1'b0);
    step(1'b1, 8'hB2, 1'b1, 1'b0);
    n_checks++;
    if ({rd_len, full_cnt, wr_bank} !== {3'd3, 2'd1, 1'b1})
      $display("FAIL flush_coinc: got %h want %h", {rd_len, full_cnt, wr_bank},
               {3'd3, 2'd1, 1'b1});
    else n_pass++;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if ({full_cnt, wr_bank, rd_bank, rd_valid} !== {2'd0, 1'b1, 1'b1, 1'b0})
      $display("FAIL flush_empty: got %h want %h", {full_cnt, wr_bank, rd_bank, rd_valid},
               {2'd0, 1'b1, 1'b1, 1'b0});
    else n_pass++;
    n_checks++;
    if (obs !== m_exp()) $display("FAIL flush_edges_model: got %h want %h", obs, m_exp());
    else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    do_reset();
    errs = 0;
    for (int i = 0; i < 600; i++) begin
      logic rr;
      rr = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0, rr);
      n_checks++;
      if (obs !== m_exp()) begin
        if (errs < 10) $display("FAIL random_cyc%0d: got %h want %h", i, obs, m_exp());
        errs++;
      end else n_pass++;
    end
  endtask

  task automatic test_reset_mid_drain();
    rst3_n = 1'b0;
    @(posedge clk); #1;
    rst3_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b_wv = 1'b1; b_wd = 8'h40 + 8'(i);
      @(posedge clk); #1;
    end
    b_wv = 1'b0;
    n_checks++;
    if ({b_rd_valid, b_rd_data, b_rd_len, b_full_cnt, b_wr_bank} !==
        {1'b1, 8'h40, 3'd5, 2'd2, 2'd2})
      $display("FAIL mid_fill: got %h want %h",
               {b_rd_valid, b_rd_data, b_rd_len, b_full_cnt, b_wr_bank},
               {1'b1, 8'h40, 3'd5, 2'd2, 2'd2});
    else n_pass++;
    b_rr = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    b_rr = 1'b0;
    n_checks++;
    if (b_rd_data !== 8'h42) $display("FAIL mid_read: got %h want 42", b_rd_data);
    else n_pass++;
    #2;
    rst3_n = 1'b0;
    #1;
    n_checks++;
    if (obs3 !== 20'b1_0_00000000_0_000_00_00_00)
      $display("FAIL mid_async_reset: got %h want %h", obs3, 20'b1_0_00000000_0_000_00_00_00);
    else n_pass++;
    @(negedge clk);
    rst3_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (obs3 !== 20'b1_0_00000000_0_000_00_00_00)
        $display("FAIL mid_after_release%0d: got %h want %h", i, obs3,
                 20'b1_0_00000000_0_000_00_00_00);
      else n_pass++;
    end
    b_wv = 1'b1; b_wd = 8'h55; b_wf = 1'b1;
    @(posedge clk); #1;
    b_wv = 1'b0; b_wf = 1'b0;
    n_checks++;
    if ({b_rd_valid, b_rd_data, b_rd_len, b_rd_last, b_wr_bank} !==
        {1'b1, 8'h55, 3'd1, 1'b1, 2'd1})
      $display("FAIL mid_new_bank: got %h want %h",
               {b_rd_valid, b_rd_data, b_rd_len, b_rd_last, b_wr_bank},
               {1'b1, 8'h55, 3'd1, 1'b1, 2'd1});
    else n_pass++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_drain();
    test_backpressure();
    test_flush();
    test_flush_edges();
    test_random();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pp_bank_ctrl.md
Name: pp_bank_ctrl

Overview:
- Parametrised N-bank ping-pong buffer with internal storage: a stream writer fills banks in rotation while a stream reader drains completed banks in the same order.
- Generalises the two-bank input select to NUM_BANKS banks.
- Adds per-bank state tracking, valid/ready handshakes, partial-bank flush with a recorded length, and end-of-bank marking.
- Sits between a producer stream and a block-oriented consumer.

Parameters:
- DATA_WIDTH, 8, word width.
- DEPTH, 16, words per bank; minimum 2; need not be a power of two.
- NUM_BANKS, 2, number of banks; minimum 2.
- Derived localparams: AW = $clog2(DEPTH); BW = max(1,$clog2(NUM_BANKS)); LW = $clog2(DEPTH+1); CW = $clog2(NUM_BANKS+1).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  write word offered.
- wr_ready  out  1  write bank can accept.
- wr_data  in  DATA_WIDTH  write word.
- wr_flush  in  1  pulse: close the partially filled write bank.
- rd_valid  out  1  read word available.
- rd_ready  in  1  consumer accepts.
- rd_data  out  DATA_WIDTH  read word; 0 when rd_valid=0.
- rd_last  out  1  current read word is the last of its bank.
- rd_len  out  LW  valid length of the bank being read; 0 when rd_valid=0.
- wr_bank  out  BW  current write bank index.
- rd_bank  out  BW  current read bank index.
- full_cnt  out  CW  number of banks in FULL or DRAINING.

Behaviour:
- Per-bank state: EMPTY, FILLING, FULL, DRAINING. Per-bank len register (LW bits). Write pointer wr_bank/wr_addr; read pointer rd_bank/rd_addr.
- Reset (async, immediate):
  - All banks EMPTY; pointers 0; len 0.
  - Outputs: wr_ready=1, rd_valid=0, rd_data=0, rd_last=0, rd_len=0, full_cnt=0.
  - Storage contents are not reset.
- wr_ready = state[wr_bank] is EMPTY or FILLING. It is combinational from registered state.
- Write accept (wr_valid & wr_ready):
  - mem[wr_bank][wr_addr] <= wr_data.
  - EMPTY becomes FILLING.
  - If wr_addr == DEPTH-1: bank goes to FULL, len = DEPTH, wr_addr = 0, and wr_bank advances (NUM_BANKS-1 wraps to 0).
  - Otherwise wr_addr increments.
- wr_flush:
  - Bank FILLING, no write that cycle: bank goes to FULL, len = wr_addr, wr_addr = 0, wr_bank advances.
  - Coincident with an accepted write: len = wr_addr+1; the written word is included. If that write also completes the bank, the result equals a normal completion.
  - Bank EMPTY: no-op.
  - Write bank not writable (FULL/DRAINING): no-op; a flush is never queued.
- rd_valid = state[rd_bank] is FULL or DRAINING (show-ahead, zero latency).
  - rd_data = mem[rd_bank][rd_addr] when valid, else 0.
  - rd_len = len[rd_bank] when valid, else 0.
  - rd_last = rd_valid & (rd_addr == len[rd_bank]-1).
- Read accept (rd_valid & rd_ready):
  - FULL becomes DRAINING.
  - On the rd_last beat: bank goes to EMPTY, rd_addr = 0, rd_bank advances with wrap.
  - Otherwise rd_addr increments.
- Latency:
  - A word becomes readable the cycle after the write completing or flushing its bank.
  - A drained bank becomes writable (wr_ready 1) the cycle after its rd_last accept.
- Simultaneous events:
  - Write and read always target different banks, so same-cycle write-complete and read-complete update independent bank states.
  - full_cnt = +1 on complete/flush, -1 on drain; net 0 when both happen in one cycle.
- All banks FULL: wr_ready=0, and wr_data is held by the producer.
- All banks EMPTY: rd_valid=0.
- Reset mid-operation: in-flight banks are discarded and are not re-presented after release.
- A wr_valid or rd_ready asserted without the matching ready/valid has no effect on state.

Decomposition:
- Shared package pp_buf_pkg:
  - 2-bit bank-state encoding: EMPTY=0, FILLING=1, FULL=2, DRAINING=3.
  - Width helper functions for BW/LW/CW.
- Sub-module pp_bank_mem:
  - One bank, DEPTH x DATA_WIDTH register array.
  - One synchronous write port (we, waddr, wdata); one asynchronous read port.
  - Instantiated NUM_BANKS times in a generate loop.
  - The controller muxes read data by rd_bank.

Test Plan (DATA_WIDTH=8, DEPTH=4, NUM_BANKS=2 unless stated):
- Reset: hold rst_n=0 then release -> wr_ready=1, rd_valid=0, rd_data=0, wr_bank=0, rd_bank=0, full_cnt=0.
- Fill/drain: write 0x10..0x13 -> cycle after 4th accept rd_valid=1, rd_data=0x10, rd_len=4, wr_bank=1, full_cnt=1; with rd_ready=1 -> read 0x10,0x11,0x12,0x13, rd_last only on 0x13, then rd_bank=1, full_cnt=0.
- Backpressure: rd_ready=0, write 8 words 0x20..0x27 -> wr_ready=0 after 8th, full_cnt=2; 9th word 0x28 held; drain bank0 -> wr_ready=1 the cycle after the 0x23 rd_last beat; 0x28 lands in bank0 addr 0.
- Flush: write 0xA0,0xA1, pulse wr_flush -> rd_len=2, read 0xA0 then 0xA1 with rd_last; next write 0xA2 goes to bank1 addr 0.
- Flush edges: write 0xB0,0xB1, then 0xB2 with wr_flush in the same cycle -> rd_len=3; wr_flush with write bank EMPTY -> no change in full_cnt or pointers.
- Reset mid-drain: NUM_BANKS=3, DEPTH=5; fill 2 banks, read 2 words, drop rst_n -> outputs return to reset values without a clock edge; after release rd_valid=0 until new writes.
